sram_port_ctrl: RTL



---
 rtl/sram_port_ctrl_if.sv | 30 +++
 rtl/sram_port_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_ctrl_if.sv
// Request/response channel between the core's load/store path and
// sram_port_ctrl. master = requester (core), slave = sram_port_ctrl.
interface sram_port_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [MASK_WIDTH-1:0] req_wmask;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_write;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_write, rsp_rdata
  );
endinterface

// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: drives one RW port of an OpenRAM macro (clk0 tied to clock).
// Reads, full writes and byte-masked writes (done as read-modify-write) are
// taken from a valid/ready request stream, one at a time; read data and write
// acks return on a valid/ready response channel. All outputs are registered.
// Optional macro SRAM_PORT_CTRL_CLEAR_EN: after reset, zero every SRAM word
// (one write per cycle) before accepting requests.
module sram_port_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clock,
  input  logic                  reset,
  sram_port_ctrl_if.slave       bus,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  // IDLE : waiting for a request (req_ready high)
  // RD   : read port cycle in flight (SRAM samples at the next edge)
  // CAP  : dout0 valid; capture it (read) or merge and issue the write (RMW)
  // MRG  : write port cycle in flight
  // WR   : write committed (or skipped for a zero mask); raise the ack
  // RESP : hold the response until rsp_ready
  // CLEAR: post-reset zeroing sweep (only used with the clear feature)
  typedef enum logic [2:0] {IDLE, RD, CAP, MRG, WR, RESP, CLEAR} state_e;

`ifdef SRAM_PORT_CTRL_CLEAR_EN
  localparam state_e RESET_STATE = CLEAR;
`else
  localparam state_e RESET_STATE = IDLE;
`endif

  state_e                state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  csb0_q, csb0_d;
  logic                  web0_q, web0_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
  logic [DATA_WIDTH-1:0] din0_q, din0_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [MASK_WIDTH-1:0] wmask_q, wmask_d;
  logic                  rmw_q, rmw_d;
  logic [DATA_WIDTH-1:0] merged;
`ifdef SRAM_PORT_CTRL_CLEAR_EN
  // One extra bit so the sweep can tell "all words written" apart from address 0.
  logic [ADDR_WIDTH:0]   clr_cnt_q, clr_cnt_d;
`endif

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign sram_csb0     = csb0_q;
  assign sram_web0     = web0_q;
  assign sram_addr0    = addr0_q;
  assign sram_din0     = din0_q;

  // Byte merge of the latched write data over the old word read back from the SRAM.
  always_comb begin
    merged = sram_dout0;
    for (int i = 0; i < MASK_WIDTH; i++) begin
      if (wmask_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  // Next-state and next-output logic for the port sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    csb0_d      = 1'b1;
    web0_d      = 1'b1;
    addr0_d     = addr0_q;
    din0_d      = din0_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    rmw_d       = rmw_q;
`ifdef SRAM_PORT_CTRL_CLEAR_EN
    clr_cnt_d   = clr_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          addr0_d = bus.req_addr;
          wdata_d = bus.req_wdata;
          wmask_d = bus.req_wmask;
          rmw_d   = 1'b0;
          if (!bus.req_write) begin
            csb0_d  = 1'b0;
            state_d = RD;
          end else if (bus.req_wmask == '1) begin
            csb0_d  = 1'b0;
            web0_d  = 1'b0;
            din0_d  = bus.req_wdata;
            state_d = MRG;
          end else if (bus.req_wmask == '0) begin
            // Nothing to write: skip the SRAM and ack on the next edge.
            state_d = WR;
          end else begin
            csb0_d  = 1'b0;
            rmw_d   = 1'b1;
            state_d = RD;
          end
        end
      end
      RD: state_d = CAP;
      CAP: begin
        if (rmw_q) begin
          // Read-to-write turnaround: old word is on dout0 now.
          csb0_d  = 1'b0;
          web0_d  = 1'b0;
          din0_d  = merged;
          state_d = MRG;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = sram_dout0;
          state_d     = RESP;
        end
      end
      MRG: state_d = WR;
      WR: begin
        rsp_valid_d = 1'b1;
        rsp_write_d = 1'b1;
        rsp_rdata_d = '0;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
`ifdef SRAM_PORT_CTRL_CLEAR_EN
      CLEAR: begin
        if (clr_cnt_q[ADDR_WIDTH]) begin
          state_d = IDLE;
        end else begin
          csb0_d    = 1'b0;
          web0_d    = 1'b0;
          addr0_d   = clr_cnt_q[ADDR_WIDTH-1:0];
          din0_d    = '0;
          clr_cnt_d = clr_cnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Only one transaction in flight: ready exactly when heading back to IDLE.
    req_ready_d = (state_d == IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= RESET_STATE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      csb0_q      <= 1'b1;
      web0_q      <= 1'b1;
      addr0_q     <= '0;
      din0_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      rmw_q       <= 1'b0;
`ifdef SRAM_PORT_CTRL_CLEAR_EN
      clr_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      csb0_q      <= csb0_d;
      web0_q      <= web0_d;
      addr0_q     <= addr0_d;
      din0_q      <= din0_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      rmw_q       <= rmw_d;
`ifdef SRAM_PORT_CTRL_CLEAR_EN
      clr_cnt_q   <= clr_cnt_d;
`endif
    end
  end
endmodule
